latch_bank_sequencer: RTL and testbench

Synchronous controller that shares one WIDTH-bit level-sensitive latch bank (D, en, active-low clear) among NREQ requesters. It arbitrates write requests and captures the winner's data. It then drives the bank's D/en/clear pins with a fixed setup → enable → hold sequence, so D never changes while en is high. It sits between the requesting datapath blocks and the latch bank, and is the only driver of the bank's control pins.

---
 rtl/latch_bank_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_latch_bank_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/latch_bank_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : latch_bank_sequencer
//  Description : Arbitrates NREQ write requesters onto one shared WIDTH-bit
//                level-sensitive latch bank. It drives D/en/clear with a
//                setup -> enable -> hold sequence so D is stable while en is
//                high. A one-cycle clear takes priority over writes.
//                Optional build macro LATCH_SEQ_FIXED_PRIO_EN selects fixed
//                priority (lowest index wins) in place of round-robin.
//  Revision    : 1.0 - initial release
// ============================================================================
module latch_bank_sequencer #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int EN_CYC    = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                  clk,
    input  logic                  Reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    input  logic                  clr_req,
    output logic [NREQ-1:0]       gnt,
    output logic                  done,
    output logic                  busy,
    output logic [WIDTH-1:0]      lat_D,
    output logic                  lat_en,
    output logic                  lat_rst_n
);

    // The one down-counter only ever holds (phase length - 1).
    localparam int c_MAX_SE  = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int c_CNT_MAX = (c_MAX_SE > HOLD_CYC) ? c_MAX_SE : HOLD_CYC;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam int c_IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_SETUP  = 3'd2,
        S_ENABLE = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;

    logic [NREQ-1:0]      r_gnt;
    logic [NREQ-1:0]      w_gnt_nxt;
    logic [WIDTH-1:0]     r_lat_D;
    logic [WIDTH-1:0]     w_data_nxt;
    logic                 r_done;
    logic                 w_done_nxt;
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic                 r_lat_en;
    logic                 w_en_nxt;
    logic                 r_lat_rst_n;
    logic                 w_rstn_nxt;

    // Arbiter results
    logic                 w_win_any;
    logic [NREQ-1:0]      w_win_onehot;
    logic [WIDTH-1:0]     w_win_data;
    int                   w_scan;

`ifndef LATCH_SEQ_FIXED_PRIO_EN
    logic [c_IDX_W-1:0]   r_last;
    logic [c_IDX_W-1:0]   w_win_idx;
`endif

    // Arbitration: first requester found scanning from the start index
    always_comb begin
        w_win_any    = 1'b0;
        w_win_onehot = '0;
        w_win_data   = '0;
        w_scan       = 0;
`ifndef LATCH_SEQ_FIXED_PRIO_EN
        w_win_idx    = '0;
`endif
        for (int i = 0; i < NREQ; i++) begin
`ifdef LATCH_SEQ_FIXED_PRIO_EN
            w_scan = i;
`else
            w_scan = (int'(r_last) + 1 + i) % NREQ;
`endif
            if (!w_win_any && (|(req & (NREQ'(1) << w_scan)))) begin
                w_win_any    = 1'b1;
                w_win_onehot = NREQ'(1) << w_scan;
                w_win_data   = WIDTH'(wdata >> (w_scan * WIDTH));
`ifndef LATCH_SEQ_FIXED_PRIO_EN
                w_win_idx    = c_IDX_W'(w_scan);
`endif
            end
        end
    end

    // Next-state, phase counter and next registered-output values
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gnt_nxt   = r_gnt;
        w_data_nxt  = r_lat_D;
        case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_state_nxt = S_CLEAR;
                    w_data_nxt  = '0;
                end else if (w_win_any) begin
                    w_state_nxt = S_SETUP;
                    w_cnt_nxt   = c_CNT_W'(SETUP_CYC - 1);
                    w_gnt_nxt   = w_win_onehot;
                    w_data_nxt  = w_win_data;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_IDLE;
            end
            S_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_ENABLE;
                    w_cnt_nxt   = c_CNT_W'(EN_CYC - 1);
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            S_ENABLE: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = c_CNT_W'(HOLD_CYC - 1);
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            S_HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
        // Outputs are decoded from the upcoming state so they are registered
        w_done_nxt = (w_state_nxt == S_CLEAR) ||
                     ((w_state_nxt == S_HOLD) && (w_cnt_nxt == '0));
        w_en_nxt   = (w_state_nxt == S_ENABLE);
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_rstn_nxt = (w_state_nxt != S_CLEAR);
    end

    // State and output registers; reset aborts any transaction at once
    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_lat_D     <= '0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_lat_en    <= 1'b0;
            r_lat_rst_n <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_gnt       <= w_gnt_nxt;
            r_lat_D     <= w_data_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= w_busy_nxt;
            r_lat_en    <= w_en_nxt;
            r_lat_rst_n <= w_rstn_nxt;
        end
    end

`ifndef LATCH_SEQ_FIXED_PRIO_EN
    // Remember the last write winner; reset value makes requester 0 first
    always_ff @(posedge clk) begin
        if (!Reset) begin
            r_last <= c_IDX_W'(NREQ - 1);
        end else if ((r_state == S_IDLE) && !clr_req && w_win_any) begin
            r_last <= w_win_idx;
        end
    end
`endif

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign busy      = r_busy;
    assign lat_D     = r_lat_D;
    assign lat_en    = r_lat_en;
    assign lat_rst_n = r_lat_rst_n;

endmodule
`default_nettype wire

// File: tb/tb_latch_bank_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_latch_bank_sequencer
//  Description : Directed self-checking bench for latch_bank_sequencer with
//                default parameters (NREQ=4, WIDTH=8, 1/2/1 cycle phases).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_latch_bank_sequencer;

    logic        clk;
    logic        Reset;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic        clr_req;
    logic [3:0]  gnt;
    logic        done;
    logic        busy;
    logic [7:0]  lat_D;
    logic        lat_en;
    logic        lat_rst_n;

    int n_cmp;
    int n_mis;

    latch_bank_sequencer #(
        .NREQ      (4),
        .WIDTH     (8),
        .SETUP_CYC (1),
        .EN_CYC    (2),
        .HOLD_CYC  (1)
    ) dut (
        .clk       (clk),
        .Reset     (Reset),
        .req       (req),
        .wdata     (wdata),
        .clr_req   (clr_req),
        .gnt       (gnt),
        .done      (done),
        .busy      (busy),
        .lat_D     (lat_D),
        .lat_en    (lat_en),
        .lat_rst_n (lat_rst_n)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Idle-state snapshot shared by several steps
    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"},  32'(gnt),  32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
        chk({tag, "_en"},   32'(lat_en), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
    endtask

    logic [3:0] exp_gnt;
    logic [7:0] exp_dat;

    initial begin
        n_cmp   = 0;
        n_mis   = 0;
        Reset   = 1'b0;
        req     = 4'h0;
        clr_req = 1'b0;
        wdata   = 32'h44A52211;

        // Reset held for 3 cycles: everything low, including latch clear
        tick(); tick(); tick();
        chk_idle("rst");
        chk("rst_D",    32'(lat_D),     32'h0);
        chk("rst_rstn", 32'(lat_rst_n), 32'h0);
        Reset = 1'b1;
        tick();
        chk("rel_rstn", 32'(lat_rst_n), 32'h1);
        chk("rel_busy", 32'(busy),      32'h0);

        // Single write from requester 2
        req = 4'b0100;
        tick();
        chk("wr_gnt",  32'(gnt),    32'h4);
        chk("wr_D",    32'(lat_D),  32'hA5);
        chk("wr_busy", 32'(busy),   32'h1);
        chk("wr_en0",  32'(lat_en), 32'h0);
        req = 4'b0000;
        tick();
        chk("wr_en1",  32'(lat_en), 32'h1);
        chk("wr_D1",   32'(lat_D),  32'hA5);
        tick();
        chk("wr_en2",  32'(lat_en), 32'h1);
        chk("wr_D2",   32'(lat_D),  32'hA5);
        chk("wr_nodone", 32'(done), 32'h0);
        tick();
        chk("wr_enoff", 32'(lat_en), 32'h0);
        chk("wr_done",  32'(done),   32'h1);
        chk("wr_gnth",  32'(gnt),    32'h4);
        tick();
        chk_idle("wr_end");
        chk("wr_keepD", 32'(lat_D), 32'hA5);

        // Fresh reset so arbitration starts from requester 0
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        wdata = 32'h44332211;

        // All four requesting continuously: five transactions, 5-cycle pitch
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
`ifdef LATCH_SEQ_FIXED_PRIO_EN
            exp_gnt = 4'b0001;
            exp_dat = 8'h11;
`else
            exp_gnt = 4'b0001 << (k % 4);
            exp_dat = 8'(8'h11 * ((k % 4) + 1));
`endif
            tick();
            chk($sformatf("rr%0d_gnt", k), 32'(gnt),   32'(exp_gnt));
            chk($sformatf("rr%0d_D", k),   32'(lat_D), 32'(exp_dat));
            if (k == 4) req = 4'b0000;
            tick(); tick(); tick();
            chk($sformatf("rr%0d_done", k), 32'(done), 32'h1);
            tick();
            chk($sformatf("rr%0d_idle", k), 32'(busy), 32'h0);
        end

        // Clear and request together: clear served first, request kept
        req     = 4'b0010;
        clr_req = 1'b1;
        tick();
        chk("clr_rstn", 32'(lat_rst_n), 32'h0);
        chk("clr_done", 32'(done),      32'h1);
        chk("clr_D",    32'(lat_D),     32'h0);
        chk("clr_gnt",  32'(gnt),       32'h0);
        chk("clr_busy", 32'(busy),      32'h1);
        clr_req = 1'b0;
        tick();
        chk("clr_rstn1", 32'(lat_rst_n), 32'h1);
        chk_idle("clr_idle");
        tick();
        chk("clr_gnt1", 32'(gnt),   32'h2);
        chk("clr_D1",   32'(lat_D), 32'h22);

        // Drop req and change wdata during ENABLE: transaction unaffected
        tick();
        chk("mid_en", 32'(lat_en), 32'h1);
        req   = 4'b0000;
        wdata = 32'hFFFFFFFF;
        tick();
        chk("mid_en2", 32'(lat_en), 32'h1);
        chk("mid_D2",  32'(lat_D),  32'h22);
        tick();
        chk("mid_done", 32'(done),  32'h1);
        chk("mid_D3",   32'(lat_D), 32'h22);
        tick();
        chk_idle("mid_end");
        chk("mid_keepD", 32'(lat_D), 32'h22);

        // Reset during ENABLE aborts the transaction at that edge
        wdata = 32'h44332211;
        req   = 4'b1000;
        tick();
`ifdef LATCH_SEQ_FIXED_PRIO_EN
        chk("ab_gnt", 32'(gnt), 32'h8);
`else
        chk("ab_gnt", 32'(gnt), 32'h8);
`endif
        chk("ab_D", 32'(lat_D), 32'h44);
        req = 4'b0000;
        tick();
        chk("ab_en", 32'(lat_en), 32'h1);
        Reset = 1'b0;
        tick();
        chk_idle("ab_rst");
        chk("ab_D0",   32'(lat_D),     32'h0);
        chk("ab_rstn", 32'(lat_rst_n), 32'h0);
        Reset = 1'b1;
        tick();
        chk("ab_rstn1", 32'(lat_rst_n), 32'h1);
        tick();
        chk_idle("ab_quiet");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
